// File: rtl/if_program_loader.sv
// Byte-stream program loader and fetch sequencer for the IF stage.
// Optional LOAD idle timeout: define IF_LOADER_TIMEOUT_EN.
module if_program_loader #(
  parameter int NB_PC          = 6,
  parameter int NB_INSTRUCTION = 32,
  parameter int NB_DATA        = 8,
  parameter logic [NB_INSTRUCTION-1:0] HALT_WORD = 32'hFFFFFFFF,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NB_DATA-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  input  logic                      i_halt_detected,
  output logic                      o_imem_write_enable,
  output logic [NB_PC-1:0]          o_imem_write_addr,
  output logic [NB_INSTRUCTION-1:0] o_imem_write_data,
  output logic                      o_pc_enable,
  output logic                      o_pc_reset,
  output logic                      o_read_enable,
  output logic [2:0]                o_state,
  output logic                      o_error
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] STEP = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [NB_DATA-1:0] CMD_L = 8'h4C;
  localparam logic [NB_DATA-1:0] CMD_C = 8'h43;
  localparam logic [NB_DATA-1:0] CMD_S = 8'h53;
  localparam logic [NB_DATA-1:0] CMD_N = 8'h4E;
  localparam logic [NB_DATA-1:0] CMD_X = 8'h58;

  localparam int NB_BYTES = NB_INSTRUCTION / NB_DATA;
  localparam int NB_CNT   = $clog2(NB_BYTES);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_BYTES - 1);
  localparam logic [NB_PC-1:0] ADDR_LAST = {{(NB_PC-2){1'b1}}, 2'b00};

  logic [2:0]                state_q, state_d;
  logic [NB_CNT-1:0]         cnt_q, cnt_d;
  logic [NB_INSTRUCTION-1:0] word_q, word_d, word_asm;
  logic [NB_PC-1:0]          addr_q, addr_d;
  logic                      we_q, we_d;
  logic [NB_PC-1:0]          waddr_q, waddr_d;
  logic [NB_INSTRUCTION-1:0] wdata_q, wdata_d;
  logic                      pe_q, pe_d;
  logic                      prst_q, prst_d;
  logic                      rd_q, rd_d;
  logic                      step_pulse;

`ifdef IF_LOADER_TIMEOUT_EN
  localparam int NB_TMO = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TIMEOUT_CYCLES - 1);
  logic [NB_TMO-1:0] tmo_q, tmo_d;
  logic              err_q, err_d;
`else
  wire unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    step_pulse = 1'b0;
    word_asm   = word_q;
    word_asm[cnt_q*NB_DATA +: NB_DATA] = i_rx_data;
`ifdef IF_LOADER_TIMEOUT_EN
    tmo_d = '0;
    err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_L) begin
            addr_d  = '0;
            cnt_d   = '0;
            word_d  = '0;
            state_d = LOAD;
          end else if (i_rx_data == CMD_C) begin
            state_d = RUN;
          end else if (i_rx_data == CMD_S) begin
            state_d = STEP;
          end
        end
      end
      LOAD: begin
        if (i_rx_valid) begin
          if (cnt_q == CNT_LAST) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = word_asm;
            cnt_d   = '0;
            word_d  = '0;
            // The top word is the last slot: hold the address, never wrap.
            if (addr_q != ADDR_LAST) addr_d = addr_q + NB_PC'(4);
            if (word_asm == HALT_WORD || addr_q == ADDR_LAST)
              state_d = IDLE;
          end else begin
            word_d = word_asm;
            cnt_d  = cnt_q + 1'b1;
          end
        end
`ifdef IF_LOADER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          cnt_d   = '0;
          word_d  = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RUN: begin
        if (i_halt_detected) state_d = DONE;
      end
      STEP: begin
        if (i_halt_detected) begin
          state_d = DONE;
        end else if (i_rx_valid) begin
          if (i_rx_data == CMD_N) step_pulse = 1'b1;
          else if (i_rx_data == CMD_C) state_d = RUN;
        end
      end
      DONE: begin
        if (i_rx_valid && i_rx_data == CMD_X) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    prst_d = (state_d == IDLE) || (state_d == LOAD);
    rd_d   = (state_d == RUN) || (state_d == STEP);
    pe_d   = (state_d == RUN) || step_pulse;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pe_q    <= 1'b0;
      prst_q  <= 1'b1;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pe_q    <= pe_d;
      prst_q  <= prst_d;
      rd_q    <= rd_d;
    end
  end

`ifdef IF_LOADER_TIMEOUT_EN
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign o_error = err_q;
`else
  assign o_error = 1'b0;
`endif

  assign o_imem_write_enable = we_q;
  assign o_imem_write_addr   = waddr_q;
  assign o_imem_write_data   = wdata_q;
  assign o_pc_enable         = pe_q;
  assign o_pc_reset          = prst_q;
  assign o_read_enable       = rd_q;
  assign o_state             = state_q;

endmodule

// File: tb/tb_if_program_loader.sv
// Directed vector bench for if_program_loader.
// Covers the IF_LOADER_TIMEOUT_EN build when that macro is defined.
module tb_if_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        halt;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        pe, prst, rd, err;
  logic [2:0]  st;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int pe_cnt = 0;

  always #5 clk = ~clk;

  if_program_loader #(
`ifdef IF_LOADER_TIMEOUT_EN
    .TIMEOUT_CYCLES(20)
`else
    .TIMEOUT_CYCLES(1000)
`endif
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .i_halt_detected(halt),
    .o_imem_write_enable(we),
    .o_imem_write_addr(waddr),
    .o_imem_write_data(wdata),
    .o_pc_enable(pe),
    .o_pc_reset(prst),
    .o_read_enable(rd),
    .o_state(st),
    .o_error(err)
  );

  always @(negedge clk) begin
    if (we === 1'b1) wr_cnt++;
    if (pe === 1'b1) pe_cnt++;
  end

  typedef struct {
    logic        rst_n, vld;
    logic [7:0]  dat;
    logic        halt, we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        pe, pr, rd;
    logic [2:0]  st;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic r, input logic vl, input logic [7:0] d,
                   input logic h, input logic w, input logic [5:0] a,
                   input logic [31:0] wd, input logic p, input logic pr,
                   input logic rr, input logic [2:0] s);
    vec_t e;
    e.rst_n = r; e.vld = vl; e.dat = d; e.halt = h; e.we = w;
    e.wa = a; e.wd = wd; e.pe = p; e.pr = pr; e.rd = rr; e.st = s;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic vl, input logic [7:0] d,
                     input logic h);
    @(negedge clk);
    rst_n = r; rx_valid = vl; rx_data = d; halt = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int cnt;
    int hit;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; halt = 1'b0;

    // rst vld dat halt | we addr data pe prst rd st
    v(0,0,8'h00,0, 0,0,0, 0,1,0,0);
    v(0,0,8'h00,0, 0,0,0, 0,1,0,0);
    v(1,1,8'h4C,0, 0,0,0, 0,1,0,1);
    v(1,1,8'h01,0, 0,0,0, 0,1,0,1);
    v(1,1,8'h02,0, 0,0,0, 0,1,0,1);
    v(1,1,8'h03,0, 0,0,0, 0,1,0,1);
    v(1,1,8'h04,0, 1,0,32'h04030201, 0,1,0,1);
    v(1,1,8'hFF,0, 0,0,0, 0,1,0,1);
    v(1,1,8'hFF,0, 0,0,0, 0,1,0,1);
    v(1,1,8'hFF,0, 0,0,0, 0,1,0,1);
    v(1,1,8'hFF,0, 1,4,32'hFFFFFFFF, 0,1,0,0);
    v(1,0,8'h00,0, 0,0,0, 0,1,0,0);
    v(1,1,8'h43,0, 0,0,0, 1,0,1,2);
    v(1,0,8'h00,0, 0,0,0, 1,0,1,2);
    v(1,1,8'h58,0, 0,0,0, 1,0,1,2);
    v(1,1,8'h4C,0, 0,0,0, 1,0,1,2);
    v(1,0,8'h00,1, 0,0,0, 0,0,0,4);
    v(1,1,8'h43,0, 0,0,0, 0,0,0,4);
    v(1,1,8'h58,0, 0,0,0, 0,1,0,0);
    v(1,1,8'h53,0, 0,0,0, 0,0,1,3);
    v(1,1,8'h4E,0, 0,0,0, 1,0,1,3);
    v(1,0,8'h00,0, 0,0,0, 0,0,1,3);
    v(1,1,8'h5A,0, 0,0,0, 0,0,1,3);
    v(1,1,8'h4E,1, 0,0,0, 0,0,0,4);
    v(1,1,8'h58,0, 0,0,0, 0,1,0,0);
    v(1,1,8'h53,0, 0,0,0, 0,0,1,3);
    v(1,1,8'h43,0, 0,0,0, 1,0,1,2);
    v(1,0,8'h00,1, 0,0,0, 0,0,0,4);
    v(1,1,8'h58,0, 0,0,0, 0,1,0,0);
    v(1,1,8'h4C,0, 0,0,0, 0,1,0,1);
    v(1,1,8'h01,0, 0,0,0, 0,1,0,1);
    v(1,1,8'h02,0, 0,0,0, 0,1,0,1);
    v(0,1,8'h03,0, 0,0,0, 0,1,0,0);
    v(1,1,8'h4C,0, 0,0,0, 0,1,0,1);
    v(1,1,8'hAA,0, 0,0,0, 0,1,0,1);
    v(1,1,8'hBB,0, 0,0,0, 0,1,0,1);
    v(1,1,8'hCC,0, 0,0,0, 0,1,0,1);
    v(1,1,8'hDD,0, 1,0,32'hDDCCBBAA, 0,1,0,1);
    v(1,1,8'h43,0, 0,0,0, 0,1,0,1);
    v(0,0,8'h00,0, 0,0,0, 0,1,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst_n, tbl[i].vld, tbl[i].dat, tbl[i].halt);
      chk($sformatf("v%0d state", i), 32'(st), 32'(tbl[i].st));
      chk($sformatf("v%0d we", i), 32'(we), 32'(tbl[i].we));
      chk($sformatf("v%0d pc_en", i), 32'(pe), 32'(tbl[i].pe));
      chk($sformatf("v%0d pc_rst", i), 32'(prst), 32'(tbl[i].pr));
      chk($sformatf("v%0d rd_en", i), 32'(rd), 32'(tbl[i].rd));
      chk($sformatf("v%0d error", i), 32'(err), 32'd0);
      if (tbl[i].we) begin
        chk($sformatf("v%0d addr", i), 32'(waddr), 32'(tbl[i].wa));
        chk($sformatf("v%0d data", i), wdata, tbl[i].wd);
      end
    end

    // Fill all 16 words; the loader must stop at the last slot.
    cyc(0,0,8'h00,0);
    cyc(1,0,8'h00,0);
    base = wr_cnt;
    cyc(1,1,8'h4C,0);
    for (int w = 0; w < 16; w++) begin
      for (int j = 0; j < 4; j++) cyc(1,1,8'(w*4+j),0);
      chk($sformatf("full w%0d we", w), 32'(we), 32'd1);
      chk($sformatf("full w%0d addr", w), 32'(waddr), 32'(w*4));
      chk($sformatf("full w%0d data", w), wdata,
          {8'(w*4+3), 8'(w*4+2), 8'(w*4+1), 8'(w*4)});
    end
    chk("full state", 32'(st), 32'd0);
    repeat (8) cyc(1,1,8'h11,0);
    chk("full write count", 32'(wr_cnt - base), 32'd16);

    // Continuous run for 10 cycles, then halt.
    cyc(1,1,8'h43,0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1,0,8'h00,0);
      if (pe === 1'b1) cnt++;
    end
    chk("run pc_en cycles", 32'(cnt), 32'd10);
    cyc(1,0,8'h00,1);
    chk("run halt pc_en", 32'(pe), 32'd0);
    chk("run halt state", 32'(st), 32'd4);
    cyc(1,1,8'h58,0);
    chk("run X state", 32'(st), 32'd0);
    chk("run X pc_rst", 32'(prst), 32'd1);

    // Single step: three spaced 'N' bytes, then 'N' racing a halt.
    cyc(1,1,8'h53,0);
    base = pe_cnt;
    repeat (3) begin
      cyc(1,1,8'h4E,0);
      repeat (4) cyc(1,0,8'h00,0);
    end
    chk("step pulses", 32'(pe_cnt - base), 32'd3);
    cyc(1,1,8'h4E,1);
    chk("step halt pc_en", 32'(pe), 32'd0);
    chk("step halt state", 32'(st), 32'd4);
    cyc(1,0,8'h00,0);
    chk("step halt pulses", 32'(pe_cnt - base), 32'd3);
    cyc(1,1,8'h58,0);

    // Idle bytes in LOAD.
    base = wr_cnt;
    cyc(1,1,8'h4C,0);
    cyc(1,1,8'h12,0);
    cyc(1,1,8'h34,0);
    hit = 0;
`ifdef IF_LOADER_TIMEOUT_EN
    for (int c = 1; c <= 100; c++) begin
      cyc(1,0,8'h00,0);
      if (err === 1'b1 && hit == 0) begin
        hit = c;
        chk("timeout state", 32'(st), 32'd0);
      end
    end
    chk("timeout cycle", 32'(hit), 32'd20);
    chk("timeout no write", 32'(wr_cnt - base), 32'd0);
`else
    for (int c = 1; c <= 100; c++) begin
      cyc(1,0,8'h00,0);
      if (err !== 1'b0) hit++;
    end
    chk("no-timeout error", 32'(hit), 32'd0);
    chk("no-timeout state", 32'(st), 32'd1);
    chk("no-timeout no write", 32'(wr_cnt - base), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
